// File: rtl/mfp_ahb_master_arbiter_pkg.sv
// Shared AHB-Lite encodings and grant-state type for the two-master arbiter.
package mfp_ahb_master_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic       HRESP_OKAY    = 1'b0;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_state_e;

  function automatic logic is_req(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/mfp_ahb_arb_starve_cnt.sv
// Saturating stall counter; flags a master that has waited STARVE_LIMIT cycles.
module mfp_ahb_arb_starve_cnt
  import mfp_ahb_master_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic starve
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = '0;
    if (stall) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign starve = (cnt_q == LIMIT);

endmodule

// File: rtl/mfp_ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: core (m0) and serial loader (m1) share one slave port.
//   state  | meaning
//   GNT_M0 | core owns the address phase (reset / park state)
//   GNT_M1 | loader owns the address phase
module mfp_ahb_master_arbiter
  import mfp_ahb_master_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,

  input  logic [31:0] m0_HADDR,
  input  logic [ 2:0] m0_HBURST,
  input  logic        m0_HMASTLOCK,
  input  logic [ 3:0] m0_HPROT,
  input  logic [ 2:0] m0_HSIZE,
  input  logic [ 1:0] m0_HTRANS,
  input  logic [31:0] m0_HWDATA,
  input  logic        m0_HWRITE,
  output logic [31:0] m0_HRDATA,
  output logic        m0_HREADY,
  output logic        m0_HRESP,

  input  logic [31:0] m1_HADDR,
  input  logic [ 2:0] m1_HBURST,
  input  logic        m1_HMASTLOCK,
  input  logic [ 3:0] m1_HPROT,
  input  logic [ 2:0] m1_HSIZE,
  input  logic [ 1:0] m1_HTRANS,
  input  logic [31:0] m1_HWDATA,
  input  logic        m1_HWRITE,
  output logic [31:0] m1_HRDATA,
  output logic        m1_HREADY,
  output logic        m1_HRESP,

  output logic [31:0] s_HADDR,
  output logic [ 2:0] s_HBURST,
  output logic        s_HMASTLOCK,
  output logic [ 3:0] s_HPROT,
  output logic [ 2:0] s_HSIZE,
  output logic [ 1:0] s_HTRANS,
  output logic [31:0] s_HWDATA,
  output logic        s_HWRITE,
  input  logic [31:0] s_HRDATA,
  input  logic        s_HREADY,
  input  logic        s_HRESP,

  output logic        gnt,
  output logic        dph_own,
  output logic [ 1:0] starve
);

  gnt_state_e state_d, state_q;
  logic       dph_own_d, dph_own_q;
  logic       req0, req1;

  assign req0 = is_req(m0_HTRANS);
  assign req1 = is_req(m1_HTRANS);

  // Hand over only at a transfer boundary: owner idle, unlocked, and slave ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GNT_M0: if (s_HREADY && m0_HTRANS == HTRANS_IDLE && !m0_HMASTLOCK && req1)
                state_d = GNT_M1;
      GNT_M1: if (s_HREADY && m1_HTRANS == HTRANS_IDLE && !m1_HMASTLOCK && req0)
                state_d = GNT_M0;
      default: state_d = GNT_M0;
    endcase
  end

  always_comb begin
    dph_own_d = dph_own_q;
    if (s_HREADY) dph_own_d = (state_q == GNT_M1);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= GNT_M0;
      dph_own_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dph_own_q <= dph_own_d;
    end
  end

  assign gnt     = (state_q == GNT_M1);
  assign dph_own = dph_own_q;

  always_comb begin
    s_HADDR     = gnt ? m1_HADDR     : m0_HADDR;
    s_HBURST    = gnt ? m1_HBURST    : m0_HBURST;
    s_HMASTLOCK = gnt ? m1_HMASTLOCK : m0_HMASTLOCK;
    s_HPROT     = gnt ? m1_HPROT     : m0_HPROT;
    s_HSIZE     = gnt ? m1_HSIZE     : m0_HSIZE;
    s_HTRANS    = gnt ? m1_HTRANS    : m0_HTRANS;
    s_HWRITE    = gnt ? m1_HWRITE    : m0_HWRITE;
    s_HWDATA    = dph_own ? m1_HWDATA : m0_HWDATA;
  end

  // A non-granted master sees an idle accepted, or a request stalled in place.
  always_comb begin
    m0_HREADY = ~req0;
    m0_HRDATA = '0;
    m0_HRESP  = HRESP_OKAY;
    m1_HREADY = ~req1;
    m1_HRDATA = '0;
    m1_HRESP  = HRESP_OKAY;
    if (gnt) begin
      m1_HREADY = s_HREADY;
      m1_HRDATA = s_HRDATA;
      m1_HRESP  = s_HRESP;
    end else begin
      m0_HREADY = s_HREADY;
      m0_HRDATA = s_HRDATA;
      m0_HRESP  = s_HRESP;
    end
  end

  mfp_ahb_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_m0 (
    .clk    (HCLK),
    .rst    (HRESET),
    .stall  (req0 & gnt),
    .starve (starve[0])
  );

  mfp_ahb_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_m1 (
    .clk    (HCLK),
    .rst    (HRESET),
    .stall  (req1 & ~gnt),
    .starve (starve[1])
  );

endmodule

// File: tb/tb_mfp_ahb_master_arbiter.sv
// Directed bench for the two-master AHB-Lite arbiter: vector table plus corner sequences.
module tb_mfp_ahb_master_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

  logic        HCLK = 1'b0, HRESET = 1'b1;
  logic [31:0] m0_HADDR, m1_HADDR, m0_HWDATA, m1_HWDATA, s_HRDATA;
  logic [ 2:0] m0_HBURST, m1_HBURST, m0_HSIZE, m1_HSIZE;
  logic [ 3:0] m0_HPROT, m1_HPROT;
  logic [ 1:0] m0_HTRANS, m1_HTRANS;
  logic        m0_HMASTLOCK, m1_HMASTLOCK, m0_HWRITE, m1_HWRITE, s_HREADY, s_HRESP;
  logic [31:0] m0_HRDATA, m1_HRDATA, s_HADDR, s_HWDATA;
  logic        m0_HREADY, m1_HREADY, m0_HRESP, m1_HRESP;
  logic [ 2:0] s_HBURST, s_HSIZE;
  logic [ 3:0] s_HPROT;
  logic [ 1:0] s_HTRANS, starve;
  logic        s_HMASTLOCK, s_HWRITE, gnt, dph_own;

  int checks = 0, errors = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_master_arbiter #(.STARVE_LIMIT(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m0_HADDR(m0_HADDR), .m0_HBURST(m0_HBURST), .m0_HMASTLOCK(m0_HMASTLOCK),
    .m0_HPROT(m0_HPROT), .m0_HSIZE(m0_HSIZE), .m0_HTRANS(m0_HTRANS),
    .m0_HWDATA(m0_HWDATA), .m0_HWRITE(m0_HWRITE), .m0_HRDATA(m0_HRDATA),
    .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP),
    .m1_HADDR(m1_HADDR), .m1_HBURST(m1_HBURST), .m1_HMASTLOCK(m1_HMASTLOCK),
    .m1_HPROT(m1_HPROT), .m1_HSIZE(m1_HSIZE), .m1_HTRANS(m1_HTRANS),
    .m1_HWDATA(m1_HWDATA), .m1_HWRITE(m1_HWRITE), .m1_HRDATA(m1_HRDATA),
    .m1_HREADY(m1_HREADY), .m1_HRESP(m1_HRESP),
    .s_HADDR(s_HADDR), .s_HBURST(s_HBURST), .s_HMASTLOCK(s_HMASTLOCK),
    .s_HPROT(s_HPROT), .s_HSIZE(s_HSIZE), .s_HTRANS(s_HTRANS),
    .s_HWDATA(s_HWDATA), .s_HWRITE(s_HWRITE), .s_HRDATA(s_HRDATA),
    .s_HREADY(s_HREADY), .s_HRESP(s_HRESP),
    .gnt(gnt), .dph_own(dph_own), .starve(starve)
  );

  typedef struct {
    logic [1:0] t0;
    logic       l0;
    logic [1:0] t1;
    logic       l1;
    logic       rdy;
    logic       e_gnt;
    logic       e_dph;
    logic       e_r0;
    logic       e_r1;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic [1:0] t0, logic l0, logic [1:0] t1, logic l1, logic rdy,
                              logic e_gnt, logic e_dph, logic e_r0, logic e_r1, logic [1:0] e_st);
    vec_t v;
    v.t0 = t0; v.l0 = l0; v.t1 = t1; v.l1 = l1; v.rdy = rdy;
    v.e_gnt = e_gnt; v.e_dph = e_dph; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_all();
    m0_HADDR = 32'h0; m0_HBURST = 3'b000; m0_HMASTLOCK = 1'b0; m0_HPROT = 4'h3;
    m0_HSIZE = 3'b010; m0_HTRANS = IDLE; m0_HWDATA = 32'h2222_2222; m0_HWRITE = 1'b0;
    m1_HADDR = 32'h0; m1_HBURST = 3'b000; m1_HMASTLOCK = 1'b0; m1_HPROT = 4'h1;
    m1_HSIZE = 3'b010; m1_HTRANS = IDLE; m1_HWDATA = 32'h1111_1111; m1_HWRITE = 1'b0;
    s_HRDATA = 32'h0; s_HREADY = 1'b1; s_HRESP = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
  endtask

  task automatic next();
    @(posedge HCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] beat_t [4];

    //             t0    l0  t1    l1  rdy  gnt dph r0 r1 st
    vecs[0]  = mk(IDLE, 0, IDLE, 0, 1,   0,  0,  1, 1, 2'b00);
    vecs[1]  = mk(NSEQ, 0, IDLE, 0, 1,   0,  0,  1, 1, 2'b00);
    vecs[2]  = mk(IDLE, 0, NSEQ, 0, 1,   0,  0,  1, 0, 2'b00);
    vecs[3]  = mk(IDLE, 0, NSEQ, 0, 1,   1,  0,  1, 1, 2'b00);
    vecs[4]  = mk(NSEQ, 0, IDLE, 0, 1,   1,  1,  0, 1, 2'b00);
    vecs[5]  = mk(NSEQ, 0, IDLE, 0, 0,   0,  1,  0, 1, 2'b00);
    vecs[6]  = mk(NSEQ, 0, NSEQ, 0, 1,   0,  1,  1, 0, 2'b00);
    vecs[7]  = mk(IDLE, 0, NSEQ, 0, 0,   0,  0,  0, 0, 2'b00);
    vecs[8]  = mk(IDLE, 0, NSEQ, 0, 1,   0,  0,  1, 0, 2'b00);
    vecs[9]  = mk(IDLE, 0, IDLE, 0, 1,   1,  0,  1, 1, 2'b00);
    vecs[10] = mk(IDLE, 0, IDLE, 0, 1,   1,  1,  1, 1, 2'b00);
    vecs[11] = mk(NSEQ, 0, IDLE, 1, 1,   1,  1,  0, 1, 2'b00);
    vecs[12] = mk(NSEQ, 0, IDLE, 0, 1,   1,  1,  0, 1, 2'b00);
    vecs[13] = mk(NSEQ, 0, IDLE, 0, 1,   0,  1,  1, 1, 2'b00);
    vecs[14] = mk(IDLE, 0, IDLE, 0, 1,   0,  0,  1, 1, 2'b00);

    // Reset state while reset is held.
    idle_all();
    m0_HADDR = 32'hA000_0000; m1_HADDR = 32'hB000_0000;
    #2;
    chk("reset_gnt", {31'b0, gnt}, 32'd0);
    chk("reset_dph", {31'b0, dph_own}, 32'd0);
    chk("reset_starve", {30'b0, starve}, 32'd0);
    chk("reset_s_haddr_m0", s_HADDR, 32'hA000_0000);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // m0 NONSEQ read of the boot vector.
    m0_HTRANS = NSEQ; m0_HADDR = 32'h1FC0_0000; m0_HWRITE = 1'b0;
    @(negedge HCLK);
    chk("a_s_haddr", s_HADDR, 32'h1FC0_0000);
    chk("a_s_htrans", {30'b0, s_HTRANS}, {30'b0, NSEQ});
    chk("a_m1_hready_idle", {31'b0, m1_HREADY}, 32'd1);
    next();
    m0_HTRANS = IDLE; s_HRDATA = 32'h3C00_0001;
    @(negedge HCLK);
    chk("a_m0_hrdata", m0_HRDATA, 32'h3C00_0001);
    chk("a_m1_hrdata_zero", m1_HRDATA, 32'h0);

    // Vector table, applied one row per cycle from reset.
    do_reset();
    m0_HADDR = 32'h0000_1000; m1_HADDR = 32'h0000_2000;
    for (int i = 0; i < 15; i++) begin
      m0_HTRANS = vecs[i].t0; m0_HMASTLOCK = vecs[i].l0;
      m1_HTRANS = vecs[i].t1; m1_HMASTLOCK = vecs[i].l1;
      s_HREADY = vecs[i].rdy; s_HRDATA = 32'h55AA_0000 + 32'(i);
      @(negedge HCLK);
      chk($sformatf("v%0d_gnt", i), {31'b0, gnt}, {31'b0, vecs[i].e_gnt});
      chk($sformatf("v%0d_dph", i), {31'b0, dph_own}, {31'b0, vecs[i].e_dph});
      chk($sformatf("v%0d_m0_hready", i), {31'b0, m0_HREADY}, {31'b0, vecs[i].e_r0});
      chk($sformatf("v%0d_m1_hready", i), {31'b0, m1_HREADY}, {31'b0, vecs[i].e_r1});
      chk($sformatf("v%0d_starve", i), {30'b0, starve}, {30'b0, vecs[i].e_st});
      chk($sformatf("v%0d_s_haddr", i), s_HADDR, vecs[i].e_gnt ? 32'h0000_2000 : 32'h0000_1000);
      chk($sformatf("v%0d_m0_hrdata", i), m0_HRDATA, vecs[i].e_gnt ? 32'h0 : 32'h55AA_0000 + 32'(i));
      next();
    end

    // m1 write switch-in: stalled one cycle, then address, then data phase.
    do_reset();
    m1_HTRANS = NSEQ; m1_HADDR = 32'h0000_0100; m1_HWRITE = 1'b1;
    @(negedge HCLK);
    chk("b_m1_hready_stall", {31'b0, m1_HREADY}, 32'd0);
    chk("b_gnt_before", {31'b0, gnt}, 32'd0);
    next();
    @(negedge HCLK);
    chk("b_gnt_after", {31'b0, gnt}, 32'd1);
    chk("b_m1_hready", {31'b0, m1_HREADY}, 32'd1);
    chk("b_s_haddr", s_HADDR, 32'h0000_0100);
    chk("b_s_hwrite", {31'b0, s_HWRITE}, 32'd1);
    next();
    m1_HTRANS = IDLE; m1_HWDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    chk("b_dph", {31'b0, dph_own}, 32'd1);
    chk("b_s_hwdata", s_HWDATA, 32'hDEAD_BEEF);
    chk("b_m1_hready_dph", {31'b0, m1_HREADY}, 32'd1);

    // m0 INCR4 burst is never interrupted by m1's request.
    do_reset();
    m1_HTRANS = NSEQ; m1_HADDR = 32'h0000_0200;
    m0_HBURST = 3'b011;
    beat_t[0] = NSEQ; beat_t[1] = SEQ; beat_t[2] = SEQ; beat_t[3] = SEQ;
    for (int k = 0; k < 4; k++) begin
      m0_HTRANS = beat_t[k]; m0_HADDR = 32'h0000_1000 + 32'(4 * k);
      @(negedge HCLK);
      chk($sformatf("c_beat%0d_gnt", k), {31'b0, gnt}, 32'd0);
      chk($sformatf("c_beat%0d_m1_hready", k), {31'b0, m1_HREADY}, 32'd0);
      chk($sformatf("c_beat%0d_s_haddr", k), s_HADDR, 32'h0000_1000 + 32'(4 * k));
      next();
    end
    m0_HTRANS = IDLE; m0_HBURST = 3'b000;
    @(negedge HCLK);
    chk("c_idle_gnt", {31'b0, gnt}, 32'd0);
    next();
    @(negedge HCLK);
    chk("c_switch_gnt", {31'b0, gnt}, 32'd1);
    chk("c_switch_s_haddr", s_HADDR, 32'h0000_0200);
    chk("c_switch_m1_hready", {31'b0, m1_HREADY}, 32'd1);

    // Locked idle owner holds the grant; m1 starves after 16 stalled cycles.
    do_reset();
    m0_HMASTLOCK = 1'b1; m1_HTRANS = NSEQ; m1_HADDR = 32'h0000_0300;
    for (int k = 1; k <= 20; k++) begin
      next();
      chk($sformatf("d_k%0d_gnt", k), {31'b0, gnt}, 32'd0);
      chk($sformatf("d_k%0d_starve1", k), {31'b0, starve[1]}, (k >= 16) ? 32'd1 : 32'd0);
    end
    m0_HMASTLOCK = 1'b0;
    next();
    chk("d_unlock_gnt", {31'b0, gnt}, 32'd1);
    next();
    chk("d_unlock_starve", {30'b0, starve}, 32'd0);

    // Wait states on an m1 write while m0 requests: everything frozen.
    do_reset();
    m1_HTRANS = NSEQ; m1_HADDR = 32'h0000_0300; m1_HWRITE = 1'b1;
    next();
    m0_HTRANS = NSEQ; m0_HADDR = 32'h0000_1004;
    @(negedge HCLK);
    chk("e_addr_gnt", {31'b0, gnt}, 32'd1);
    chk("e_addr_m1_hready", {31'b0, m1_HREADY}, 32'd1);
    next();
    m1_HTRANS = IDLE; m1_HWDATA = 32'hCAFE_F00D; s_HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk($sformatf("e_ws%0d_gnt", k), {31'b0, gnt}, 32'd1);
      chk($sformatf("e_ws%0d_dph", k), {31'b0, dph_own}, 32'd1);
      chk($sformatf("e_ws%0d_s_hwdata", k), s_HWDATA, 32'hCAFE_F00D);
      chk($sformatf("e_ws%0d_m1_hready", k), {31'b0, m1_HREADY}, 32'd0);
      chk($sformatf("e_ws%0d_m0_hready", k), {31'b0, m0_HREADY}, 32'd0);
      next();
    end
    s_HREADY = 1'b1;
    @(negedge HCLK);
    chk("e_ready_gnt", {31'b0, gnt}, 32'd1);
    chk("e_ready_m1_hready", {31'b0, m1_HREADY}, 32'd1);
    next();
    @(negedge HCLK);
    chk("e_back_gnt", {31'b0, gnt}, 32'd0);
    chk("e_back_dph", {31'b0, dph_own}, 32'd1);
    chk("e_back_s_haddr", s_HADDR, 32'h0000_1004);

    // Asynchronous reset during an m1 data phase, with m0 already starved.
    do_reset();
    m1_HTRANS = NSEQ; m1_HMASTLOCK = 1'b1; m1_HWRITE = 1'b1; m1_HADDR = 32'h0000_0400;
    next();
    m0_HTRANS = NSEQ; m0_HADDR = 32'h0000_1008;
    for (int k = 0; k < 16; k++) next();
    chk("f_pre_gnt", {31'b0, gnt}, 32'd1);
    chk("f_pre_dph", {31'b0, dph_own}, 32'd1);
    chk("f_pre_starve", {30'b0, starve}, 32'd1);
    #2;
    HRESET = 1'b1;
    #1;
    chk("f_rst_gnt", {31'b0, gnt}, 32'd0);
    chk("f_rst_dph", {31'b0, dph_own}, 32'd0);
    chk("f_rst_starve", {30'b0, starve}, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    m1_HTRANS = IDLE; m1_HMASTLOCK = 1'b0;
    m0_HTRANS = NSEQ; m0_HADDR = 32'h1FC0_0010;
    @(negedge HCLK);
    chk("f_post_s_haddr", s_HADDR, 32'h1FC0_0010);
    chk("f_post_m0_hready", {31'b0, m0_HREADY}, 32'd1);
    chk("f_post_gnt", {31'b0, gnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_master_arbiter.md
# mfp_ahb_master_arbiter

Two-master AHB-Lite arbiter that shares the single `mfp_ahb` slave port between the MIPS core (master 0) and the serial-loader bridge (master 1). It replaces a combinational `in_progress` multiplexer with cycle-correct grant switching. Grants change only at transfer boundaries, and `HMASTLOCK` is honoured. It sits between the two masters and `mfp_ahb` inside the top-level with-loader wrapper.

## Interface
- `STARVE_LIMIT`, default 16: number of consecutive stalled-request cycles after which a master's starve flag asserts. Legal range is 1..255.
- `HCLK` in 1: system clock; all state updates on the rising edge.
- `HRESET` in 1: reset, asynchronous, active-high.
- `m0_HADDR`/`m1_HADDR` in 32: master address.
- `m0_HBURST`/`m1_HBURST` in 3; `m0_HPROT`/`m1_HPROT` in 4; `m0_HSIZE`/`m1_HSIZE` in 3: master controls, forwarded unchanged.
- `m0_HTRANS`/`m1_HTRANS` in 2: transfer type; a master is requesting when `HTRANS[1]`=1.
- `m0_HMASTLOCK`/`m1_HMASTLOCK` in 1; `m0_HWRITE`/`m1_HWRITE` in 1; `m0_HWDATA`/`m1_HWDATA` in 32.
- `m0_HRDATA`/`m1_HRDATA` out 32; `m0_HREADY`/`m1_HREADY` out 1; `m0_HRESP`/`m1_HRESP` out 1: per-master response.
- `s_HADDR`, `s_HBURST`, `s_HMASTLOCK`, `s_HPROT`, `s_HSIZE`, `s_HTRANS`, `s_HWDATA`, `s_HWRITE` out: slave side, same widths as the master inputs.
- `s_HRDATA` in 32; `s_HREADY` in 1; `s_HRESP` in 1: slave response.
- `gnt` out 1: address-phase owner (0 = core, 1 = loader).
- `dph_own` out 1: data-phase owner.
- `starve` out 2: per-master starvation flag.

## Operation
- Two-state grant FSM: `GNT_M0` and `GNT_M1`. Reset state is `GNT_M0`.
- Switch condition, GNT_Mx to GNT_My: `s_HREADY`=1, the owner's `HTRANS`=IDLE, the owner's `HMASTLOCK`=0, and My is requesting.
- Otherwise the grant holds. With no requests, the grant parks on the last owner.
- The owner is never switched mid-burst: while it presents BUSY, SEQ or NONSEQ, the grant holds.
- Address/control mux: the `s_*` address and control signals come from the master selected by `gnt`.
- `dph_own` is a register loaded with `gnt` on every cycle with `s_HREADY`=1. `s_HWDATA` is selected by `dph_own`.
- Granted master: `HREADY`=`s_HREADY`, `HRDATA`=`s_HRDATA`, `HRESP`=`s_HRESP`.
- Non-granted master: `HREADY`=~`HTRANS[1]`. An IDLE is accepted harmlessly; a request is stalled with its address held. `HRDATA`=0 and `HRESP`=OKAY.
- Starvation counters, one per master:
  - Increment when the master requests and is not granted; saturate at `STARVE_LIMIT`.
  - Clear when the master is granted or stops requesting.
  - `starve[i]` = (count == `STARVE_LIMIT`). The flag is status only and does not force preemption.
- Loader traffic occurs while the core is held in reset, so the core idles and the loader always wins within one boundary.

## Timing
- Reset values: `gnt`=0, `dph_own`=0, counters=0, `starve`=0, slave outputs driven from m0.
- Grant switch latency: the new owner's address appears on `s_*` the cycle after the qualifying edge. That address is accepted when `s_HREADY`=1 in that cycle.
- The IDLE-data phase of the loser completes with zero wait states.
- Wait states: with `s_HREADY`=0, `gnt` and `dph_own` are frozen and the granted master's `HREADY` is 0.
- Simultaneous events:
  - Owner goes IDLE while the other requests in the same cycle: switch.
  - Both masters request while the owner is locked: hold until the lock is released AND the owner is IDLE.
- Reset mid-transfer: all state returns to reset values immediately (asynchronous). No response is owed.

## Structure
- Add the shared constants to `mfp_ahb_const.vh`: `HTRANS_IDLE`=2'b00, `HTRANS_BUSY`=01, `HTRANS_NONSEQ`=10, `HTRANS_SEQ`=11, `HRESP_OKAY`=0.
- One sub-module, `mfp_ahb_arb_starve_cnt`: a saturating counter parameterised by `STARVE_LIMIT`, instantiated once per master. Counter width = `$clog2(STARVE_LIMIT+1)`.

## Test plan
- Reset, then m0 NONSEQ read 0x1FC0_0000: `s_HADDR`=0x1FC0_0000 in the same cycle, `m0_HRDATA`=`s_HRDATA` in the next cycle, `m1_HREADY`=1 while m1 is IDLE.
- m0 IDLE and m1 NONSEQ write 0x0000_0100 with data 0xDEADBEEF: `gnt`=1 after one edge, `s_HWDATA`=0xDEADBEEF in the data phase, and `m1_HREADY` is low for exactly one cycle.
- m0 in an INCR4 burst while m1 requests: `gnt` stays 0 through all four beats and switches only once m0 presents IDLE. `m1_HREADY`=0 throughout the burst.
- m0 `HMASTLOCK`=1 with IDLE for 20 cycles while m1 requests: no switch, and `starve[1]` rises on cycle 16 (STARVE_LIMIT=16). After the lock drops: switch and `starve[1]`=0.
- Slave inserts 3 wait states on an m1 write while m0 requests: `gnt`/`dph_own` stay frozen, `s_HWDATA` is held, and the switch back to m0 occurs only after m1 goes IDLE with `s_HREADY`=1.
- `HRESET` pulsed during an m1 data phase: `gnt`=0, `dph_own`=0 and `starve`=0 asynchronously; the next m0 NONSEQ is forwarded normally.
